// File: rtl/alu_operand_sequencer_if.sv
// Board-side bundle between the raw switch/button inputs and the latched ALU operands.
// The master drives the raw inputs and the slave (the sequencer) drives the latched outputs.
interface alu_operand_sequencer_if #(
  parameter int N = 4
);
  logic [N-1:0] sw_data;
  logic [1:0]   sw_mode;
  logic [3:0]   btn_n;
  logic [N-1:0] a_num;
  logic [N-1:0] b_num;
  logic [3:0]   op_buttons;
  logic [1:0]   change_mode;
  logic [1:0]   state_o;
  logic         op_valid;
  logic         load_pulse;

  modport master (
    output sw_data, sw_mode, btn_n,
    input  a_num, b_num, op_buttons, change_mode, state_o, op_valid, load_pulse
  );

  modport slave (
    input  sw_data, sw_mode, btn_n,
    output a_num, b_num, op_buttons, change_mode, state_o, op_valid, load_pulse
  );
endinterface

// File: rtl/alu_operand_sequencer.sv
// ALU front-end: synchronises and debounces the push buttons, turns presses into events,
// and walks an A -> B -> OP -> SHOW entry FSM that latches operands, op and mode.
module alu_operand_sequencer #(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  alu_operand_sequencer_if.slave bus
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    WAIT_A  = 2'b00,
    WAIT_B  = 2'b01,
    WAIT_OP = 2'b10,
    SHOW    = 2'b11
  } state_t;

  // Active-low one-hot op vector for a 2-bit selector.
  function automatic logic [3:0] op_onehot_n(input logic [1:0] sel);
    logic [3:0] v;
    case (sel)
      2'b00:   v = 4'b1110;
      2'b01:   v = 4'b1101;
      2'b10:   v = 4'b1011;
      2'b11:   v = 4'b0111;
      default: v = 4'b1111;
    endcase
    return v;
  endfunction

  logic [3:0]    sync1_r, sync2_r, deb_r, deb_nxt_s;
  logic [CW-1:0] cnt_r     [4];
  logic [CW-1:0] cnt_nxt_s [4];
  // Delayed debounced level and press events for ENTER/BACK/CLEAR only: {clear, back, enter}.
  logic [2:0]    deb_d_r, ev_r;

  state_t        state_r, state_nxt_s;
  logic [N-1:0]  a_r, a_nxt_s, b_r, b_nxt_s;
  logic [3:0]    op_r, op_nxt_s;
  logic [1:0]    mode_r, mode_nxt_s;
  logic          op_valid_r, load_r, load_nxt_s;

  // Two-flop synchroniser; flops idle at the released level so reset release is quiet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 4'b1111;
      sync2_r <= 4'b1111;
    end else begin
      sync1_r <= bus.btn_n;
      sync2_r <= sync1_r;
    end
  end

  // Per-button debounce: count disagreeing samples, flip after DEBOUNCE_CYCLES in a row.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_nxt_s[i] = '0;
      deb_nxt_s[i] = deb_r[i];
      if (sync2_r[i] == deb_r[i]) begin
        cnt_nxt_s[i] = '0;
      end else if (cnt_r[i] == CNT_MAX) begin
        deb_nxt_s[i] = ~deb_r[i];
        cnt_nxt_s[i] = '0;
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_r <= 4'b1111;
      for (int i = 0; i < 4; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      deb_r <= deb_nxt_s;
      for (int i = 0; i < 4; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
    end
  end

  // Press events: registered 1->0 transition of the debounced level; the reserved button is dropped here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_d_r <= 3'b111;
      ev_r    <= 3'b000;
    end else begin
      deb_d_r <= {deb_r[3], deb_r[1], deb_r[0]};
      ev_r    <= deb_d_r & ~{deb_r[3], deb_r[1], deb_r[0]};
    end
  end

  // Entry FSM next-state and next register values; CLEAR beats ENTER beats BACK.
  always_comb begin
    state_nxt_s = state_r;
    a_nxt_s     = a_r;
    b_nxt_s     = b_r;
    op_nxt_s    = op_r;
    mode_nxt_s  = mode_r;
    load_nxt_s  = 1'b0;
    if (ev_r[2]) begin
      state_nxt_s = WAIT_A;
      a_nxt_s     = '0;
      b_nxt_s     = '0;
      op_nxt_s    = 4'b1111;
      mode_nxt_s  = 2'b00;
    end else if (ev_r[0]) begin
      load_nxt_s = 1'b1;
      case (state_r)
        WAIT_A: begin
          a_nxt_s     = bus.sw_data;
          state_nxt_s = WAIT_B;
        end
        WAIT_B: begin
          b_nxt_s     = bus.sw_data;
          state_nxt_s = WAIT_OP;
        end
        WAIT_OP: begin
          op_nxt_s    = op_onehot_n(bus.sw_data[1:0]);
          mode_nxt_s  = bus.sw_mode;
          state_nxt_s = SHOW;
        end
        SHOW: begin
          op_nxt_s    = 4'b1111;
          state_nxt_s = WAIT_A;
        end
        default: state_nxt_s = WAIT_A;
      endcase
    end else if (ev_r[1]) begin
      case (state_r)
        WAIT_A:  state_nxt_s = WAIT_A;
        WAIT_B:  state_nxt_s = WAIT_A;
        WAIT_OP: state_nxt_s = WAIT_B;
        SHOW: begin
          op_nxt_s    = 4'b1111;
          state_nxt_s = WAIT_OP;
        end
        default: state_nxt_s = WAIT_A;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // FSM state and latched output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= WAIT_A;
      a_r        <= '0;
      b_r        <= '0;
      op_r       <= 4'b1111;
      mode_r     <= 2'b00;
      op_valid_r <= 1'b0;
      load_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      a_r        <= a_nxt_s;
      b_r        <= b_nxt_s;
      op_r       <= op_nxt_s;
      mode_r     <= mode_nxt_s;
      op_valid_r <= (state_nxt_s == SHOW);
      load_r     <= load_nxt_s;
    end
  end

  assign bus.a_num       = a_r;
  assign bus.b_num       = b_r;
  assign bus.op_buttons  = op_r;
  assign bus.change_mode = mode_r;
  assign bus.state_o     = state_r;
  assign bus.op_valid    = op_valid_r;
  assign bus.load_pulse  = load_r;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer: directed button sequences with literal expectations,
// plus a cycle-by-cycle comparison against a behavioural model of the entry rules.
module tb_alu_operand_sequencer;

  localparam int N = 4;
  localparam int D = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;
  logic chk_en = 1'b0;

  alu_operand_sequencer_if #(.N(N)) bus ();

  alu_operand_sequencer #(.N(N), .DEBOUNCE_CYCLES(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: a button level is accepted after D consecutive synced samples
  // disagree with it; a press acts on the FSM two edges after acceptance.
  logic [D-1:0] m_hist [4];
  logic [3:0]   m_s1, m_s2, m_deb, m_fell, m_ev, m_act;
  logic [3:0]   m_a, m_b, m_op;
  logic [1:0]   m_mode;
  int           m_st;
  logic         m_load;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int b = 0; b < 4; b++) m_hist[b] = {D{1'b1}};
        m_s1 = 4'hF; m_s2 = 4'hF; m_deb = 4'hF; m_fell = 4'h0; m_ev = 4'h0;
        m_a = 4'h0; m_b = 4'h0; m_op = 4'hF; m_mode = 2'b00; m_st = 0; m_load = 1'b0;
      end else begin
        m_act  = m_ev;
        m_ev   = m_fell;
        m_fell = 4'h0;
        for (int b = 0; b < 4; b++) begin
          m_hist[b] = {m_hist[b][D-2:0], m_s2[b]};
          if (m_hist[b] == {D{~m_deb[b]}}) begin
            m_fell[b] = m_deb[b];
            m_deb[b]  = ~m_deb[b];
          end
        end
        m_s2 = m_s1;
        m_s1 = bus.btn_n;
        m_load = 1'b0;
        if (m_act[3]) begin
          m_a = 4'h0; m_b = 4'h0; m_op = 4'hF; m_mode = 2'b00; m_st = 0;
        end else if (m_act[0]) begin
          m_load = 1'b1;
          if (m_st == 0) begin
            m_a = bus.sw_data; m_st = 1;
          end else if (m_st == 1) begin
            m_b = bus.sw_data; m_st = 2;
          end else if (m_st == 2) begin
            m_op = 4'hF ^ (4'h1 << bus.sw_data[1:0]); m_mode = bus.sw_mode; m_st = 3;
          end else begin
            m_op = 4'hF; m_st = 0;
          end
        end else if (m_act[1]) begin
          if (m_st == 1) m_st = 0;
          else if (m_st == 2) m_st = 1;
          else if (m_st == 3) begin
            m_st = 2; m_op = 4'hF;
          end
        end
      end
    end
  end

  // Compare the DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_a_num",       8'(bus.a_num),       8'(m_a));
      check("m_b_num",       8'(bus.b_num),       8'(m_b));
      check("m_op_buttons",  8'(bus.op_buttons),  8'(m_op));
      check("m_change_mode", 8'(bus.change_mode), 8'(m_mode));
      check("m_state",       8'(bus.state_o),     8'(m_st));
      check("m_op_valid",    8'(bus.op_valid),    8'(m_st == 3));
      check("m_load_pulse",  8'(bus.load_pulse),  8'(m_load));
    end
  end

  task automatic press(input logic [3:0] mask, input int hold, output int pulses);
    pulses = 0;
    bus.btn_n = ~mask;
    for (int i = 0; i < hold + 14; i++) begin
      if (i == hold) bus.btn_n = 4'hF;
      @(posedge clk); #1;
      pulses += int'(bus.load_pulse);
    end
  endtask

  int p;

  initial begin
    bus.sw_data = 4'h0;
    bus.sw_mode = 2'b00;
    bus.btn_n   = 4'hF;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 8'(bus.state_o), 8'h00);
    check("rst_op", 8'(bus.op_buttons), 8'h0F);
    check("rst_a", 8'(bus.a_num), 8'h00);
    check("rst_valid", 8'(bus.op_valid), 8'h00);

    // Full entry sequence
    bus.sw_data = 4'h5; press(4'b0001, 6, p);
    check("seq_a", 8'(bus.a_num), 8'h05);
    check("seq_st1", 8'(bus.state_o), 8'h01);
    bus.sw_data = 4'h3; press(4'b0001, 6, p);
    check("seq_b", 8'(bus.b_num), 8'h03);
    check("seq_st2", 8'(bus.state_o), 8'h02);
    bus.sw_data = 4'h0; bus.sw_mode = 2'b00; press(4'b0001, 6, p);
    check("seq_op", 8'(bus.op_buttons), 8'h0E);
    check("seq_mode", 8'(bus.change_mode), 8'h00);
    check("seq_valid", 8'(bus.op_valid), 8'h01);

    // BACK from SHOW
    press(4'b0010, 6, p);
    check("back_show_st", 8'(bus.state_o), 8'h02);
    bus.sw_data = 4'h2; press(4'b0001, 6, p);
    check("op2", 8'(bus.op_buttons), 8'h0B);
    press(4'b0010, 6, p);
    check("back_st", 8'(bus.state_o), 8'h02);
    check("back_op", 8'(bus.op_buttons), 8'h0F);
    check("back_b", 8'(bus.b_num), 8'h03);
    check("back_pulse", 8'(p), 8'h00);

    // Back down to WAIT_A, then BACK has no effect
    press(4'b0010, 6, p);
    press(4'b0010, 6, p);
    check("wa_st", 8'(bus.state_o), 8'h00);
    press(4'b0010, 6, p);
    check("wa_back_st", 8'(bus.state_o), 8'h00);
    check("wa_back_a", 8'(bus.a_num), 8'h05);
    check("wa_back_b", 8'(bus.b_num), 8'h03);

    // Short glitch is ignored
    bus.sw_data = 4'h9; press(4'b0001, 3, p);
    check("glitch_pulse", 8'(p), 8'h00);
    check("glitch_st", 8'(bus.state_o), 8'h00);

    // Latency: pulse exactly at edge t+7
    bus.btn_n = 4'b1110;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check($sformatf("lat_%0d", i), 8'(bus.load_pulse), 8'(i == 7));
    end
    bus.btn_n = 4'hF;
    repeat (12) @(posedge clk);
    #1;
    check("lat_a", 8'(bus.a_num), 8'h09);
    check("lat_st", 8'(bus.state_o), 8'h01);

    // Long hold gives one event; re-press gives a second
    bus.sw_data = 4'h4; press(4'b0001, 100, p);
    check("hold_pulses", 8'(p), 8'h01);
    check("hold_st", 8'(bus.state_o), 8'h02);
    check("hold_b", 8'(bus.b_num), 8'h04);
    bus.sw_data = 4'h1; bus.sw_mode = 2'b10; press(4'b0001, 6, p);
    check("repress_pulses", 8'(p), 8'h01);
    check("repress_st", 8'(bus.state_o), 8'h03);
    check("repress_op", 8'(bus.op_buttons), 8'h0D);
    check("repress_mode", 8'(bus.change_mode), 8'h02);

    // ENTER from SHOW, then climb to WAIT_OP with a_num=9
    press(4'b0001, 6, p);
    check("show_enter_st", 8'(bus.state_o), 8'h00);
    check("show_enter_mode", 8'(bus.change_mode), 8'h02);
    bus.sw_data = 4'h9; press(4'b0001, 6, p);
    press(4'b0001, 6, p);
    check("pri_pre_st", 8'(bus.state_o), 8'h02);
    check("pri_pre_a", 8'(bus.a_num), 8'h09);
    press(4'b1001, 6, p);
    check("pri_st", 8'(bus.state_o), 8'h00);
    check("pri_a", 8'(bus.a_num), 8'h00);
    check("pri_b", 8'(bus.b_num), 8'h00);
    check("pri_mode", 8'(bus.change_mode), 8'h00);
    check("pri_pulse", 8'(p), 8'h00);

    // Reserved button does nothing
    bus.sw_data = 4'h6; press(4'b0100, 6, p);
    check("rsv_st", 8'(bus.state_o), 8'h00);
    check("rsv_a", 8'(bus.a_num), 8'h00);
    check("rsv_pulse", 8'(p), 8'h00);

    // Asynchronous reset mid-sequence
    bus.sw_data = 4'h7; press(4'b0001, 6, p);
    bus.sw_data = 4'h8; press(4'b0001, 6, p);
    check("pre_rst_b", 8'(bus.b_num), 8'h08);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_a", 8'(bus.a_num), 8'h00);
    check("arst_b", 8'(bus.b_num), 8'h00);
    check("arst_st", 8'(bus.state_o), 8'h00);
    check("arst_op", 8'(bus.op_buttons), 8'h0F);
    check("arst_valid", 8'(bus.op_valid), 8'h00);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("post_rst_st", 8'(bus.state_o), 8'h00);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
